// File: rtl/flash_sample_streamer.sv
`default_nettype none
// ============================================================================
// Module   : flash_sample_streamer
// Purpose  : Walks an inclusive sample-address range, issues one flash read
//            per sample, buffers the results in a FWFT FIFO and streams them
//            to the DAC side over valid/ready.
// Options  : FLASH_STREAM_LOOP_EN - wrap to the start address instead of
//            finishing, streaming continuously until stopped.
// Revision : 1.0 - initial release
// ============================================================================
module flash_sample_streamer #(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_play,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  output logic              o_flash_start,
  output logic [ADDR_W-1:0] o_flash_addr,
  input  logic [DATA_W-1:0] i_flash_data,
  input  logic              i_flash_ack,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_sample_valid,
  input  logic              i_sample_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [ADDR_W-1:0]   r_end;
`ifdef FLASH_STREAM_LOOP_EN
  logic [ADDR_W-1:0]   r_start;
`endif

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic                w_latch;
  logic                w_push;
  logic                w_pop;
  logic                w_flush;
  logic                w_flash_start;
  logic                w_done;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_latch       = 1'b0;
    w_push        = 1'b0;
    w_flush       = 1'b0;
    w_flash_start = 1'b0;
    w_done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_play && !i_stop) begin
          w_latch    = 1'b1;
          w_addr_nxt = i_start_addr;
          if (i_start_addr > i_end_addr) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (i_stop) begin
          w_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_count < c_DEPTH) begin
          // Room is guaranteed for the single outstanding read
          w_flash_start = 1'b1;
          w_state_nxt   = S_WAIT;
        end
      end

      S_WAIT: begin
        if (i_stop) begin
          if (i_flash_ack) begin
            w_flush     = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_FLUSH;
          end
        end else if (i_flash_ack) begin
          w_push = 1'b1;
          // Compare before incrementing so the top address never wraps
          if (r_addr == r_end) begin
`ifdef FLASH_STREAM_LOOP_EN
            w_addr_nxt  = r_start;
            w_state_nxt = S_REQ;
`else
            w_state_nxt = S_DRAIN;
`endif
          end else begin
            w_addr_nxt  = r_addr + 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end

      S_DRAIN: begin
        if (i_stop) begin
          w_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_count == '0) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      S_FLUSH: begin
        if (i_flash_ack) begin
          w_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_end   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      if (w_latch) begin
        r_end <= i_end_addr;
      end
    end
  end

`ifdef FLASH_STREAM_LOOP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_start <= '0;
    end else if (w_latch) begin
      r_start <= i_start_addr;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Sample FIFO (first-word fall-through)
  // --------------------------------------------------------------------------
  assign w_pop = (r_count != '0) && i_sample_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_flash_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_flash_start  = w_flash_start;
  assign o_flash_addr   = r_addr;
  assign o_sample       = r_mem[r_rd_ptr];
  assign o_sample_valid = (r_count != '0);
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = w_done;

endmodule
`default_nettype wire

// File: tb/tb_flash_sample_streamer.sv
`default_nettype none
// Testbench for flash_sample_streamer: reader model with 25-cycle latency,
// table-driven single-pass ranges plus backpressure, stop and priority cases.
module tb_flash_sample_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        play;
  logic        stop;
  logic [20:0] start_addr;
  logic [20:0] end_addr;
  logic        flash_start;
  logic [20:0] flash_addr;
  logic [31:0] flash_data;
  logic        flash_ack;
  logic [31:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_cnt  = 0;
  int done_cnt = 0;
  logic [20:0] req_q[$];
  logic [31:0] out_q[$];

  flash_sample_streamer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_play         (play),
    .i_stop         (stop),
    .i_start_addr   (start_addr),
    .i_end_addr     (end_addr),
    .o_flash_start  (flash_start),
    .o_flash_addr   (flash_addr),
    .i_flash_data   (flash_data),
    .i_flash_ack    (flash_ack),
    .o_sample       (sample),
    .o_sample_valid (sample_valid),
    .i_sample_ready (sample_ready),
    .o_busy         (busy),
    .o_done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data(input logic [20:0] a);
    return {8'hA5, 3'b000, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reader model: ack 25 cycles after the request, address must stay put
  always begin : reader
    logic [20:0] a;
    @(negedge clk);
    if (flash_start) begin
      a = flash_addr;
      repeat (25) @(posedge clk);
      #1;
      flash_ack  = 1'b1;
      flash_data = exp_data(a);
      ack_cnt++;
      @(negedge clk);
      chk("addr_held", flash_addr, a);
      @(posedge clk);
      #1;
      flash_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (flash_start) req_q.push_back(flash_addr);
    if (sample_valid && sample_ready) out_q.push_back(sample);
    if (done) done_cnt++;
  end

`ifndef FLASH_STREAM_LOOP_EN
  typedef struct {
    logic [20:0] s;
    logic [20:0] e;
    int          n_req;
  } vec_t;

  task automatic check_stream(input logic [20:0] s, input int n);
    chk("req_count", req_q.size(), n);
    chk("out_count", out_q.size(), n);
    for (int i = 0; i < n; i++) begin
      logic [20:0] a;
      a = s + 21'(i);
      if (i < req_q.size()) chk("req_addr", req_q[i], a);
      if (i < out_q.size()) chk("sample", out_q[i], exp_data(a));
    end
  endtask

  task automatic run_pass(input vec_t v);
    req_q.delete();
    out_q.delete();
    done_cnt     = 0;
    start_addr   = v.s;
    end_addr     = v.e;
    sample_ready = 1'b1;
    play = 1'b1;
    tick();
    play = 1'b0;
    for (int c = 0; c < 3000 && done_cnt == 0; c++) tick();
    repeat (3) tick();
    check_stream(v.s, v.n_req);
    chk("done_once", done_cnt, 1);
    chk("busy_after", busy, 0);
    chk("valid_after", sample_valid, 0);
  endtask
`endif

  initial begin
    rst          = 1'b1;
    play         = 1'b0;
    stop         = 1'b0;
    start_addr   = '0;
    end_addr     = '0;
    flash_ack    = 1'b0;
    flash_data   = '0;
    sample_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", flash_start, 0);
    chk("rst_addr", flash_addr, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_sample", sample, 0);
    tick();

`ifdef FLASH_STREAM_LOOP_EN
    req_q.delete();
    done_cnt   = 0;
    start_addr = 21'd2;
    end_addr   = 21'd3;
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (300) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int c = 0; c < 100 && busy; c++) tick();
    tick();
    chk("loop_req_min", req_q.size() >= 6, 1);
    for (int i = 0; i < 6 && i < req_q.size(); i++)
      chk("loop_addr", req_q[i], (i % 2 == 1) ? 21'd3 : 21'd2);
    chk("loop_no_done", done_cnt, 0);
    chk("loop_busy", busy, 0);
    chk("loop_valid", sample_valid, 0);
`else
    begin
      vec_t vecs[4];
      vecs[0] = '{s: 21'h000010, e: 21'h000013, n_req: 4};
      vecs[1] = '{s: 21'h1FFFFE, e: 21'h1FFFFF, n_req: 2};
      vecs[2] = '{s: 21'h000005, e: 21'h000004, n_req: 0};
      vecs[3] = '{s: 21'h000007, e: 21'h000007, n_req: 1};
      for (int i = 0; i < 4; i++) run_pass(vecs[i]);
    end

    // start > end: done within 3 cycles of play, no request
    req_q.delete();
    done_cnt   = 0;
    start_addr = 21'd5;
    end_addr   = 21'd4;
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (3) tick();
    chk("empty_done_fast", done_cnt, 1);
    chk("empty_no_req", req_q.size(), 0);
    chk("empty_busy", busy, 0);

    // stop and play together: stop wins
    stop = 1'b1;
    play = 1'b1;
    tick();
    stop = 1'b0;
    play = 1'b0;
    @(negedge clk);
    chk("stop_beats_play", busy, 0);
    tick();

    // Backpressure: FIFO fills, requests stall, then resume
    req_q.delete();
    out_q.delete();
    done_cnt     = 0;
    ack_cnt      = 0;
    sample_ready = 1'b0;
    start_addr   = 21'd0;
    end_addr     = 21'h1F;
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (100) tick();
    start_addr = 21'h100;
    end_addr   = 21'h101;
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (300) tick();
    chk("bp_acks", ack_cnt, 8);
    chk("bp_reqs", req_q.size(), 8);
    chk("bp_valid", sample_valid, 1);
    chk("bp_no_pop", out_q.size(), 0);
    sample_ready = 1'b1;
    for (int c = 0; c < 3000 && done_cnt == 0; c++) tick();
    repeat (3) tick();
    check_stream(21'd0, 32);
    chk("bp_done", done_cnt, 1);
    chk("bp_busy", busy, 0);

    // Stop while a read is outstanding
    req_q.delete();
    out_q.delete();
    done_cnt   = 0;
    start_addr = 21'h40;
    end_addr   = 21'h4F;
    play = 1'b1;
    tick();
    play = 1'b0;
    for (int c = 0; c < 20 && req_q.size() == 0; c++) tick();
    repeat (9) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        seen = flash_ack;
      end
      chk("stop_ack_seen", seen, 1);
    end
    @(negedge clk);
    chk("stop_idle", busy, 0);
    chk("stop_empty", sample_valid, 0);
    repeat (40) tick();
    chk("stop_reqs", req_q.size(), 1);
    chk("stop_discard", out_q.size(), 0);
    chk("stop_no_done", done_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
